fetch_sequencer: RTL and testbench

- Sequences the compiled-code instruction ROM: drives the ROM word address (program counter), captures the 3-word read window, decodes command length (1-3 words), and presents one masked instruction per handshake to the execution stage.
- Handles sequential advance, jump redirect, HALT, and range/encoding faults.
- Sits between the instruction ROM (combinational read, 96-bit window, word0 in bits [31:0]) and the executor.

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the code ROM, decodes 1-3 word commands,
// and hands one masked instruction per handshake to the executor.
module fetch_sequencer #(
  parameter int          MEM_WORDS  = 58,
  parameter logic [31:0] START_ADDR = 32'd0,
  parameter logic [5:0]  HALT_OP    = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_addr,
  input  logic [95:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [95:0] instr_data,
  output logic [1:0]  instr_len,
  output logic [31:0] instr_pc,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    s_idle,
    s_fetch,
    s_present,
    s_halted,
    s_fault
  } state_t;

  localparam logic [32:0] MEM_END = 33'(MEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  dec_len;
  logic [5:0]  dec_op;
  logic [32:0] dec_end;
  logic [32:0] seq_next;
  logic [95:0] masked;
  logic        jump_bad;

  assign rom_addr = pc;
  assign dec_len  = rom_data[31:30];
  assign dec_op   = rom_data[29:24];
  assign dec_end  = {1'b0, pc} + {31'b0, dec_len};
  assign seq_next = {1'b0, pc} + {31'b0, instr_len};
  assign jump_bad = ({1'b0, jump_target} >= MEM_END);

  // Words beyond the command length are zeroed so the executor never sees
  // bytes belonging to the following command.
  always_comb begin
    masked = '0;
    case (dec_len)
      2'd1:    masked = {64'b0, rom_data[31:0]};
      2'd2:    masked = {32'b0, rom_data[63:0]};
      2'd3:    masked = rom_data;
      default: masked = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= s_idle;
      pc          <= START_ADDR;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_len   <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      retired     <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (start) begin
            pc      <= START_ADDR;
            retired <= '0;
            state   <= s_fetch;
          end
        end

        s_fetch: begin
          if (dec_len == 2'd0) begin
            fault      <= 1'b1;
            fault_code <= 2'd1;
            state      <= s_fault;
          end else if (dec_end > MEM_END) begin
            fault      <= 1'b1;
            fault_code <= 2'd2;
            state      <= s_fault;
          end else if (dec_op == HALT_OP) begin
            halted <= 1'b1;
            state  <= s_halted;
          end else begin
            instr_data  <= masked;
            instr_len   <= dec_len;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= s_present;
          end
        end

        s_present: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            if (jump_valid) begin
              if (jump_bad) begin
                fault      <= 1'b1;
                fault_code <= 2'd3;
                state      <= s_fault;
              end else begin
                pc    <= jump_target;
                state <= s_fetch;
              end
            // Running off the end of the ROM is caught here so FETCH never
            // addresses past the last valid word.
            end else if (seq_next >= MEM_END) begin
              fault      <= 1'b1;
              fault_code <= 2'd2;
              state      <= s_fault;
            end else begin
              pc    <= seq_next[31:0];
              state <= s_fetch;
            end
          end
        end

        s_halted, s_fault: begin
          if (start) begin
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
            retired    <= '0;
            pc         <= START_ADDR;
            state      <= s_fetch;
          end
        end

        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a small behavioural ROM.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] rom_addr;
  logic [95:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [95:0] instr_data;
  logic [1:0]  instr_len;
  logic [31:0] instr_pc;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  logic [31:0] rom [0:63];
  logic [5:0]  ridx;

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .halted      (halted),
    .fault       (fault),
    .fault_code  (fault_code),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM window, reads past the array return zero.
  always_comb begin
    ridx     = rom_addr[5:0];
    rom_data = '0;
    if (rom_addr < 32'd62)
      rom_data = {rom[ridx + 6'd2], rom[ridx + 6'd1], rom[ridx]};
  end

  task automatic applyStimulus(input logic s, input logic r, input logic jv,
                               input logic [31:0] jt);
    start       = s;
    instr_ready = r;
    jump_valid  = jv;
    jump_target = jt;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] obs,
                             input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]  = 32'h40000001;
    rom[1]  = 32'h80000002;
    rom[2]  = 32'hAAAA0000;
    rom[3]  = 32'h7F000000;
    rom[10] = 32'h40000010;
    rom[56] = 32'hC0000000;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("rst_valid",   96'(instr_valid), 96'd0);
    checkOutput("rst_data",    instr_data,       96'd0);
    checkOutput("rst_len",     96'(instr_len),   96'd0);
    checkOutput("rst_pc",      96'(instr_pc),    96'd0);
    checkOutput("rst_halted",  96'(halted),      96'd0);
    checkOutput("rst_fault",   96'(fault),       96'd0);
    checkOutput("rst_code",    96'(fault_code),  96'd0);
    checkOutput("rst_retired", 96'(retired),     96'd0);
    checkOutput("rst_addr",    96'(rom_addr),    96'd0);
    rst_n = 1'b1;
    tick();

    // Sequential run: len1 at 0, len2 at 1, HALT at 3
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("lat_valid0", 96'(instr_valid), 96'd0);
    tick();
    checkOutput("i0_valid", 96'(instr_valid), 96'd1);
    checkOutput("i0_pc",    96'(instr_pc),    96'd0);
    checkOutput("i0_len",   96'(instr_len),   96'd1);
    checkOutput("i0_data",  instr_data,       {64'h0, 32'h40000001});
    tick();
    checkOutput("i0_drop",  96'(instr_valid), 96'd0);
    checkOutput("i0_ret",   96'(retired),     96'd1);
    checkOutput("i1_addr",  96'(rom_addr),    96'd1);
    tick();
    checkOutput("i1_pc",    96'(instr_pc),    96'd1);
    checkOutput("i1_len",   96'(instr_len),   96'd2);
    checkOutput("i1_data",  instr_data,       {32'h0, 32'hAAAA0000, 32'h80000002});
    tick();
    checkOutput("i2_addr",  96'(rom_addr),    96'd3);
    tick();
    checkOutput("halt_flag",  96'(halted),      96'd1);
    checkOutput("halt_ret",   96'(retired),     96'd2);
    checkOutput("halt_addr",  96'(rom_addr),    96'd3);
    checkOutput("halt_valid", 96'(instr_valid), 96'd0);

    // Restart with ready low: outputs must hold and jump must be ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("rs_halted", 96'(halted),  96'd0);
    checkOutput("rs_ret",    96'(retired), 96'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 2), 32'd10);
      tick();
      checkOutput("stall_valid", 96'(instr_valid), 96'd1);
      checkOutput("stall_pc",    96'(instr_pc),    96'd0);
      checkOutput("stall_data",  instr_data,       {64'h0, 32'h40000001});
      checkOutput("stall_addr",  96'(rom_addr),    96'd0);
      checkOutput("stall_ret",   96'(retired),     96'd0);
    end

    // Handshake with jump to 10, then jump to 58 (out of range)
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd10);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("jmp_addr", 96'(rom_addr), 96'd10);
    checkOutput("jmp_ret",  96'(retired),  96'd1);
    tick();
    checkOutput("jmp_pc",    96'(instr_pc),    96'd10);
    checkOutput("jmp_valid", 96'(instr_valid), 96'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd58);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("jf_fault", 96'(fault),       96'd1);
    checkOutput("jf_code",  96'(fault_code),  96'd3);
    checkOutput("jf_ret",   96'(retired),     96'd2);
    checkOutput("jf_valid", 96'(instr_valid), 96'd0);
    tick();
    checkOutput("jf_hold",  96'(fault_code),  96'd3);

    // Restart from FAULT: cleared, first instruction two cycles later
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("fr_fault", 96'(fault),       96'd0);
    checkOutput("fr_code",  96'(fault_code),  96'd0);
    checkOutput("fr_ret",   96'(retired),     96'd0);
    checkOutput("fr_lat",   96'(instr_valid), 96'd0);
    tick();
    checkOutput("fr_valid", 96'(instr_valid), 96'd1);
    checkOutput("fr_pc",    96'(instr_pc),    96'd0);

    // Advance once, then assert reset during PRESENT
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("pr_valid", 96'(instr_valid), 96'd1);
    checkOutput("pr_pc",    96'(instr_pc),    96'd1);
    checkOutput("pr_ret",   96'(retired),     96'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 96'(instr_valid), 96'd0);
    checkOutput("ar_ret",   96'(retired),     96'd0);
    checkOutput("ar_addr",  96'(rom_addr),    96'd0);
    checkOutput("ar_pc",    96'(instr_pc),    96'd0);
    checkOutput("ar_len",   96'(instr_len),   96'd0);
    checkOutput("ar_data",  instr_data,       96'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("rr_valid", 96'(instr_valid), 96'd1);
    checkOutput("rr_pc",    96'(instr_pc),    96'd0);
    checkOutput("rr_ret",   96'(retired),     96'd0);

    // Illegal length at PC 0
    rst_n = 1'b0;
    rom[0] = 32'h00000000;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("il_valid0", 96'(instr_valid), 96'd0);
    tick();
    checkOutput("il_fault",  96'(fault),       96'd1);
    checkOutput("il_code",   96'(fault_code),  96'd1);
    checkOutput("il_valid1", 96'(instr_valid), 96'd0);
    tick();
    checkOutput("il_valid2", 96'(instr_valid), 96'd0);

    // 3-word command at PC 56 overruns the ROM
    rom[0] = 32'h40000001;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("or_valid", 96'(instr_valid), 96'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd56);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("or_addr", 96'(rom_addr), 96'd56);
    tick();
    checkOutput("or_fault", 96'(fault),       96'd1);
    checkOutput("or_code",  96'(fault_code),  96'd2);
    checkOutput("or_ret",   96'(retired),     96'd1);
    checkOutput("or_valid", 96'(instr_valid), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
